// File: rtl/mac_block_accum_if.sv
// Handshake bundle between the multiply-add result stream, mac_block_accum and its consumer.
// Carries the sample input, clear, the block output register and the status outputs.
`ifndef DATA_WIDTH_OUT
`define DATA_WIDTH_OUT 16
`endif

interface mac_block_accum_if #(
   parameter int unsigned DATA_WIDTH_OUT = `DATA_WIDTH_OUT,
   parameter int unsigned BLOCK_LEN      = 8
);
   localparam int unsigned IN_W  = DATA_WIDTH_OUT + 1;
   localparam int unsigned CNT_W = $clog2(BLOCK_LEN);
   localparam int unsigned ACC_W = IN_W + CNT_W;

   logic [IN_W-1:0]  in_data;
   logic             in_valid;
   logic             clear;
   logic [ACC_W-1:0] out_sum;
   logic [IN_W-1:0]  out_max;
   logic             out_valid;
   logic             out_ready;
   logic             overrun;
   logic [CNT_W-1:0] blk_cnt;

   // Producer/consumer side of the block.
   modport master (
      output in_data, in_valid, clear, out_ready,
      input  out_sum, out_max, out_valid, overrun, blk_cnt
   );

   // The accumulator itself.
   modport slave (
      input  in_data, in_valid, clear, out_ready,
      output out_sum, out_max, out_valid, overrun, blk_cnt
   );
endinterface

// File: rtl/mac_block_accum.sv
// Sums consecutive BLOCK_LEN samples of the multiply-add result stream into a one-entry output register.
// Define BLOCK_ACC_MAX_EN to also track the per-block maximum; otherwise out_max is tied to zero.
`ifndef DATA_WIDTH_OUT
`define DATA_WIDTH_OUT 16
`endif

module mac_block_accum #(
   parameter int unsigned DATA_WIDTH_OUT = `DATA_WIDTH_OUT,
   parameter int unsigned BLOCK_LEN      = 8
) (
   input logic              clk,
   input logic              reset,
   mac_block_accum_if.slave bus
);
   localparam int unsigned IN_W  = DATA_WIDTH_OUT + 1;
   localparam int unsigned CNT_W = $clog2(BLOCK_LEN);
   localparam int unsigned ACC_W = IN_W + CNT_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } ostate_e;

   ostate_e          ost_q, ost_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] out_sum_q, out_sum_d;
   logic             ovr_q, ovr_d;

   logic [ACC_W-1:0] sum_new;
   logic             take;
   logic             complete;
   logic             accept;
   logic             load;

`ifdef BLOCK_ACC_MAX_EN
   logic [IN_W-1:0]  mx_q, mx_d;
   logic [IN_W-1:0]  out_max_q, out_max_d;
   logic [IN_W-1:0]  max_new;
`endif

   always_comb begin
      take     = bus.in_valid && !bus.clear;
      complete = take && (cnt_q == LAST);
      accept   = (ost_q == FULL) && bus.out_ready;
      // An accept in the completing cycle frees the slot, so the new block still lands.
      load     = complete && ((ost_q == EMPTY) || accept);
      sum_new  = acc_q + ACC_W'(bus.in_data);
`ifdef BLOCK_ACC_MAX_EN
      // The first sample of a block is taken as-is rather than compared against leftovers.
      max_new  = ((cnt_q == '0) || (bus.in_data > mx_q)) ? bus.in_data : mx_q;
`endif

      cnt_d     = cnt_q;
      acc_d     = acc_q;
      ovr_d     = ovr_q;
      ost_d     = ost_q;
      out_sum_d = out_sum_q;
`ifdef BLOCK_ACC_MAX_EN
      mx_d      = mx_q;
      out_max_d = out_max_q;
`endif

      if (bus.clear) begin
         cnt_d = '0;
         acc_d = '0;
         ovr_d = 1'b0;
`ifdef BLOCK_ACC_MAX_EN
         mx_d  = '0;
`endif
      end else if (take) begin
         if (complete) begin
            cnt_d = '0;
            acc_d = '0;
`ifdef BLOCK_ACC_MAX_EN
            mx_d  = '0;
`endif
            if (!load) begin
               ovr_d = 1'b1;
            end
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = sum_new;
`ifdef BLOCK_ACC_MAX_EN
            mx_d  = max_new;
`endif
         end
      end

      if (load) begin
         ost_d     = FULL;
         out_sum_d = sum_new;
`ifdef BLOCK_ACC_MAX_EN
         out_max_d = max_new;
`endif
      end else if (accept) begin
         ost_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ost_q     <= EMPTY;
         cnt_q     <= '0;
         acc_q     <= '0;
         ovr_q     <= 1'b0;
         out_sum_q <= '0;
`ifdef BLOCK_ACC_MAX_EN
         mx_q      <= '0;
         out_max_q <= '0;
`endif
      end else begin
         ost_q     <= ost_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         ovr_q     <= ovr_d;
         out_sum_q <= out_sum_d;
`ifdef BLOCK_ACC_MAX_EN
         mx_q      <= mx_d;
         out_max_q <= out_max_d;
`endif
      end
   end

   assign bus.out_sum   = out_sum_q;
   assign bus.out_valid = (ost_q == FULL);
   assign bus.overrun   = ovr_q;
   assign bus.blk_cnt   = cnt_q;
`ifdef BLOCK_ACC_MAX_EN
   assign bus.out_max   = out_max_q;
`else
   assign bus.out_max   = '0;
`endif
endmodule

// File: doc/mac_block_accum.md
# mac_block_accum

Downstream stage of the pipelined multiply-add unit: consumes its `data_out` result stream, sums consecutive groups of BLOCK_LEN results, and presents each block sum (plus, optionally, the block maximum) through a one-entry valid/ready output register. The upstream multiply-add is free-running and cannot be stalled. When a block completes while the output register is still held, the new block is dropped and a sticky overrun flag is raised.

## Interface
- DATA_WIDTH_OUT, default `` `DATA_WIDTH_OUT `` (16): the upstream result is DATA_WIDTH_OUT+1 bits wide.
- BLOCK_LEN, default 8: samples per block, ≥2.
- Derived localparam IN_W = DATA_WIDTH_OUT+1.
- Derived localparam ACC_W = IN_W + $clog2(BLOCK_LEN).
- clk  in  1  the single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  IN_W  unsigned result sample from the multiply-add stage.
- in_valid  in  1  in_data is valid this cycle.
- clear  in  1  synchronous discard of the partial block and the overrun flag.
- out_sum  out  ACC_W  sum of the completed block.
- out_max  out  IN_W  largest sample of the completed block.
- out_valid  out  1  output register holds an unconsumed block.
- out_ready  in  1  consumer accepts the output this cycle.
- overrun  out  1  sticky: at least one completed block was dropped.
- blk_cnt  out  $clog2(BLOCK_LEN)  samples already in the current partial block.

## Operation
- All arithmetic is unsigned. The sum register is ACC_W wide and cannot overflow.
- Internal state:
  - sample counter `cnt` (0..BLOCK_LEN-1)
  - running sum `acc`
  - running max `mx`
  - output register (`out_sum`, `out_max`, `out_valid`)
  - `overrun`
- Output register states:
  - EMPTY (`out_valid`=0) → FULL on block completion.
  - FULL → EMPTY on `out_valid && out_ready` when no completion occurs in the same cycle.
  - FULL stays FULL when a completion and an accept coincide; the output is reloaded with the new block.
- Accepted sample (`in_valid`=1, `clear`=0):
  - If `cnt` < BLOCK_LEN-1: `acc` += in_data, `mx` = max(`mx`, in_data), `cnt`++.
  - If `cnt` = BLOCK_LEN-1 (completion):
    - Completed values are `acc`+in_data and max(`mx`, in_data).
    - `cnt`, `acc` and `mx` return to 0.
    - Load the output register if it is EMPTY or being accepted this cycle. Otherwise drop the block and set `overrun`=1.
- First sample of a block: `mx` is loaded directly, not compared against a stale value.
- `clear`=1:
  - Sets `cnt`, `acc`, `mx` and `overrun` to 0.
  - Discards any same-cycle in_data.
  - Does not touch the output register; an `out_ready` accept in the same cycle still completes.
- `reset`=1 has priority over everything. It zeroes all state, including the output register and `overrun`, and abandons any partial block.
- No combinational path from `out_ready` to any output.

## Timing
- Reset values: `out_sum`=0, `out_max`=0, `out_valid`=0, `overrun`=0, `blk_cnt`=0.
- Latency: last sample of a block sampled at edge N → `out_valid`=1 with the result after edge N (visible in cycle N+1).
- Gap-free throughput: one sample per clock, one block every BLOCK_LEN clocks. A consumer holding `out_ready`=1 never causes an overrun.
- `in_valid` gaps are allowed at any point; the counter simply holds.
- `overrun` rises one cycle after the dropping completion and stays high until `clear` or `reset`.
- `out_sum`/`out_max` stay stable while `out_valid`=1 and `out_ready`=0.

## Configuration
- Macro `BLOCK_ACC_MAX_EN`.
- Defined: max tracking logic is present and `out_max` behaves as above.
- Undefined:
  - The `mx` register and its comparator are removed.
  - `out_max` is tied to 0.
  - The port remains so that instantiations do not change.
  - Sum, handshake and overrun behaviour are identical.

## Test plan
- Basic block: BLOCK_LEN=4, DATA_WIDTH_OUT=16, `out_ready`=1; send 1,2,3,4 on consecutive cycles → one-cycle later `out_valid`=1, `out_sum`=10, `out_max`=4; `blk_cnt` back to 0.
- Width corner: four samples of 17'h1FFFF → `out_sum`=19'h7FFFC, `out_max`=17'h1FFFF; no truncation.
- Backpressure/overrun:
  - Hold `out_ready`=0 and stream 8 samples (1..8) → first block held (`out_sum`=10).
  - Second block (26) is dropped and `overrun`=1.
  - Raise `out_ready` → `out_sum`=10 is accepted, then `out_valid`=0.
  - Pulse `clear` → `overrun`=0.
- Simultaneous accept and completion: `out_valid`=1, `out_ready`=1 in the same cycle the next block completes → `out_valid` stays 1, `out_sum` updates to the new sum, `overrun` stays 0.
- Gaps and clear:
  - Send 5, idle 3 cycles, send 7, then pulse `clear` together with `in_valid` (data 100) → `blk_cnt`=0, 100 is discarded.
  - Then send 1,1,1,1 → `out_sum`=4.
- Mid-block reset: after 2 of 4 samples assert `reset` for one cycle → all outputs 0. The next 4 samples (2,2,2,2) give `out_sum`=8. With `BLOCK_ACC_MAX_EN` undefined, `out_max`=0 throughout.
